mem_arb: RTL and testbench

Two-requester arbiter and sequencer for the core's single data-memory bus. The instruction-fetch port and the load/store port (driven by the memory unit's `is_load`/`is_store`, `daddr`, `dwmask` and `dwdata` outputs) share one bus. The block has at most one transaction outstanding and issues it with a req/gnt/rvalid handshake. It returns each response to the requester that owns the transaction, prevents fetch starvation, and converts a lost response into an error response.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb.sv | 131 +++++++++++++
 tb/tb_mem_arb.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the data-memory bus arbiter: owner id, FSM states
// and the registered bus request bundle.
package mem_arb_pkg;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DP = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/mem_arb.sv
// Fetch / load-store arbiter and sequencer for the single data-memory bus.
// One transaction in flight: IDLE picks a winner, REQ holds the bus request
// until accepted, WAIT returns the response (or a timeout error) to the owner.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_i_req,
    input  logic [31:0] if_i_addr,
    output logic        if_o_gnt,
    output logic        if_o_rvalid,
    output logic [31:0] if_o_rdata,
    output logic        if_o_err,
    input  logic        dp_i_is_load,
    input  logic        dp_i_is_store,
    input  logic [31:0] dp_i_addr,
    input  logic [3:0]  dp_i_wmask,
    input  logic [31:0] dp_i_wdata,
    output logic        dp_o_gnt,
    output logic        dp_o_rvalid,
    output logic [31:0] dp_o_rdata,
    output logic        dp_o_err,
    output logic        bus_o_req,
    output logic        bus_o_we,
    output logic [31:0] bus_o_addr,
    output logic [3:0]  bus_o_wmask,
    output logic [31:0] bus_o_wdata,
    input  logic        bus_i_gnt,
    input  logic        bus_i_rvalid,
    input  logic [31:0] bus_i_rdata
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [1:0]    state, state_nxt;
    logic          owner;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    bus_req_t      breq;

    logic dp_pend, if_win, dp_win, rsp_ok, rsp_tmo, rsp;

    assign dp_pend = dp_i_is_load | dp_i_is_store;
    // Data has priority unless fetch has been passed over STARVE_LIMIT times.
    assign if_win  = (state == ST_IDLE) && if_i_req &&
                     (!dp_pend || starve_cnt == SW'(STARVE_LIMIT));
    assign dp_win  = (state == ST_IDLE) && dp_pend && !if_win;

    // A real response beats a timeout landing in the same cycle.
    assign rsp_ok  = (state == ST_WAIT) && bus_i_rvalid;
    assign rsp_tmo = (state == ST_WAIT) && !bus_i_rvalid && tmo_cnt == TW'(TIMEOUT - 1);
    assign rsp     = rsp_ok | rsp_tmo;

    // Grants are combinational from IDLE; gate them so reset forces them low.
    assign if_o_gnt    = rst & if_win;
    assign dp_o_gnt    = rst & dp_win;

    assign if_o_rvalid = rsp && owner == OWN_IF;
    assign if_o_err    = rsp_tmo && owner == OWN_IF;
    assign if_o_rdata  = (rsp_ok && owner == OWN_IF) ? bus_i_rdata : '0;

    assign dp_o_rvalid = rsp && owner == OWN_DP;
    assign dp_o_err    = rsp_tmo && owner == OWN_DP;
    // Store acks carry no data.
    assign dp_o_rdata  = (rsp_ok && owner == OWN_DP && !breq.we) ? bus_i_rdata : '0;

    // bus_o_req follows the state register, so reset drops it asynchronously.
    assign bus_o_req   = (state == ST_REQ);
    assign bus_o_we    = breq.we;
    assign bus_o_addr  = breq.addr;
    assign bus_o_wmask = breq.wmask;
    assign bus_o_wdata = breq.wdata;

    // Next-state logic for the IDLE/REQ/WAIT sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (if_win || dp_win) state_nxt = ST_REQ;
            ST_REQ:  if (bus_i_gnt)        state_nxt = ST_WAIT;
            ST_WAIT: if (rsp)              state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    // State, owner and bus request registers; the request is captured at grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            owner <= OWN_IF;
            breq  <= '0;
        end else begin
            state <= state_nxt;
            if (if_win) begin
                owner <= OWN_IF;
                breq  <= '{we: 1'b0, addr: if_i_addr, wmask: 4'b0000, wdata: 32'h0};
            end else if (dp_win) begin
                owner <= OWN_DP;
                breq  <= '{we: dp_i_is_store, addr: dp_i_addr, wmask: dp_i_wmask,
                           wdata: dp_i_wdata};
            end
        end
    end

    // Saturating count of data grants taken while fetch was waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (dp_win && if_i_req) begin
            if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
        end else if (if_win || dp_win) begin
            starve_cnt <= '0;
        end
    end

    // Cycles spent in WAIT; restarted when the bus accepts the request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == ST_REQ && bus_i_gnt) begin
            tmo_cnt <= '0;
        end else if (state == ST_WAIT && !rsp) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios with literal checks,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arb;

    localparam int SL  = 4;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_i_req;
    logic [31:0] if_i_addr;
    logic        if_o_gnt, if_o_rvalid, if_o_err;
    logic [31:0] if_o_rdata;
    logic        dp_i_is_load, dp_i_is_store;
    logic [31:0] dp_i_addr, dp_i_wdata;
    logic [3:0]  dp_i_wmask;
    logic        dp_o_gnt, dp_o_rvalid, dp_o_err;
    logic [31:0] dp_o_rdata;
    logic        bus_o_req, bus_o_we;
    logic [31:0] bus_o_addr, bus_o_wdata;
    logic [3:0]  bus_o_wmask;
    logic        bus_i_gnt, bus_i_rvalid;
    logic [31:0] bus_i_rdata;

    int checks = 0;
    int failures = 0;

    mem_arb #(.STARVE_LIMIT(SL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_i_req(if_i_req), .if_i_addr(if_i_addr), .if_o_gnt(if_o_gnt),
        .if_o_rvalid(if_o_rvalid), .if_o_rdata(if_o_rdata), .if_o_err(if_o_err),
        .dp_i_is_load(dp_i_is_load), .dp_i_is_store(dp_i_is_store),
        .dp_i_addr(dp_i_addr), .dp_i_wmask(dp_i_wmask), .dp_i_wdata(dp_i_wdata),
        .dp_o_gnt(dp_o_gnt), .dp_o_rvalid(dp_o_rvalid), .dp_o_rdata(dp_o_rdata),
        .dp_o_err(dp_o_err),
        .bus_o_req(bus_o_req), .bus_o_we(bus_o_we), .bus_o_addr(bus_o_addr),
        .bus_o_wmask(bus_o_wmask), .bus_o_wdata(bus_o_wdata),
        .bus_i_gnt(bus_i_gnt), .bus_i_rvalid(bus_i_rvalid), .bus_i_rdata(bus_i_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, {if_o_gnt, if_o_rvalid, if_o_err, dp_o_gnt, dp_o_rvalid,
                             dp_o_err, bus_o_req, bus_o_we}, 64'h0);
        chk({name, "_rdata"}, {if_o_rdata, dp_o_rdata}, 64'h0);
        chk({name, "_bus"}, {bus_o_addr, bus_o_wdata}, 64'h0);
        chk({name, "_mask"}, bus_o_wmask, 64'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model (timestamps, not states) ----------
    bit          m_busy;
    bit          m_own_dp, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mask;
    int          m_bgnt_at;     // cycle the bus accepted, -1 while not yet
    int          m_streak;      // data grants in a row with fetch waiting
    int          cyc;
    logic        e_ig, e_dg, e_ir, e_ie, e_dr, e_de, e_br;
    logic [31:0] e_ird, e_drd;

    // One compare process: predict every output from the model, then compare.
    always @(negedge clk) begin
        if (!rst) begin
            chk_zero("reset");
            m_busy = 0; m_streak = 0; m_bgnt_at = -1; cyc = 0;
        end else begin
            {e_ig, e_dg, e_ir, e_ie, e_dr, e_de, e_br} = '0;
            e_ird = '0; e_drd = '0;
            if (!m_busy) begin
                if (if_i_req && (!(dp_i_is_load || dp_i_is_store) || m_streak >= SL)) begin
                    e_ig = 1; m_busy = 1; m_own_dp = 0; m_we = 0;
                    m_addr = if_i_addr; m_mask = 4'h0; m_wdata = 32'h0;
                    m_streak = 0; m_bgnt_at = -1;
                end else if (dp_i_is_load || dp_i_is_store) begin
                    e_dg = 1; m_busy = 1; m_own_dp = 1; m_we = dp_i_is_store;
                    m_addr = dp_i_addr; m_mask = dp_i_wmask; m_wdata = dp_i_wdata;
                    m_streak = if_i_req ? ((m_streak < SL) ? m_streak + 1 : SL) : 0;
                    m_bgnt_at = -1;
                end
            end else if (m_bgnt_at < 0) begin
                e_br = 1;
                if (bus_i_gnt) m_bgnt_at = cyc;
            end else begin
                if (bus_i_rvalid || cyc - m_bgnt_at == TMO) begin
                    if (m_own_dp) begin
                        e_dr = 1; e_de = !bus_i_rvalid;
                        e_drd = (bus_i_rvalid && !m_we) ? bus_i_rdata : 32'h0;
                    end else begin
                        e_ir = 1; e_ie = !bus_i_rvalid;
                        e_ird = bus_i_rvalid ? bus_i_rdata : 32'h0;
                    end
                    m_busy = 0;
                end
            end
            chk("gnt", {if_o_gnt, dp_o_gnt}, {e_ig, e_dg});
            chk("if_rsp", {if_o_rvalid, if_o_err, if_o_rdata}, {e_ir, e_ie, e_ird});
            chk("dp_rsp", {dp_o_rvalid, dp_o_err, dp_o_rdata}, {e_dr, e_de, e_drd});
            chk("bus_req", bus_o_req, e_br);
            if (e_br) begin
                chk("bus_we_mask", {bus_o_we, bus_o_wmask}, {m_we, m_mask});
                chk("bus_addr", bus_o_addr, m_addr);
                if (m_own_dp) chk("bus_wdata", bus_o_wdata, m_wdata);
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    logic [9:0] ord;
    int         n, tw;
    logic       g_if, g_dp;

    initial begin
        rst = 0; if_i_req = 0; if_i_addr = 0;
        dp_i_is_load = 0; dp_i_is_store = 0; dp_i_addr = 0; dp_i_wmask = 0; dp_i_wdata = 0;
        bus_i_gnt = 0; bus_i_rvalid = 0; bus_i_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("rst_hold");
        step(); rst = 1;

        // Single load
        step(); dp_i_is_load = 1; dp_i_addr = 32'h100;
        @(negedge clk); chk("ld_gnt_c0", dp_o_gnt, 1);
        step(); dp_i_is_load = 0; bus_i_gnt = 1;
        @(negedge clk); chk("ld_req_c1", {bus_o_req, bus_o_we, bus_o_addr}, {2'b10, 32'h100});
        step(); bus_i_gnt = 0; bus_i_rvalid = 1; bus_i_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("ld_rsp_c2", {dp_o_rvalid, dp_o_err, dp_o_rdata}, {2'b10, 32'hDEADBEEF});
        chk("ld_if_quiet", if_o_rvalid, 0);
        step(); bus_i_rvalid = 0;

        // Store held against a stalled bus
        step(); dp_i_is_store = 1; dp_i_addr = 32'h203; dp_i_wmask = 4'b1000;
        dp_i_wdata = 32'hAB000000;
        @(negedge clk); chk("st_gnt", dp_o_gnt, 1);
        step(); dp_i_is_store = 0; dp_i_addr = 32'h0; dp_i_wdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("st_bus_hold", {bus_o_req, bus_o_we, bus_o_wmask, bus_o_addr},
                {2'b11, 4'b1000, 32'h203});
            chk("st_wdata_hold", bus_o_wdata, 32'hAB000000);
            step();
        end
        bus_i_gnt = 1;
        step(); bus_i_gnt = 0; bus_i_rvalid = 1; bus_i_rdata = 32'h12345678;
        @(negedge clk); chk("st_ack", {dp_o_rvalid, dp_o_err, dp_o_rdata}, {2'b10, 32'h0});
        step(); bus_i_rvalid = 0;

        // Starvation: both requesters held continuously
        step(); if_i_req = 1; if_i_addr = 32'h1000; dp_i_is_load = 1; dp_i_addr = 32'h400;
        bus_i_gnt = 1; bus_i_rvalid = 1; bus_i_rdata = 32'hCAFE0001;
        ord = '0; n = 0;
        for (int k = 0; k < 60 && n < 10; k++) begin
            @(negedge clk);
            if (if_o_gnt) begin ord[n] = 1'b1; n++; end
            else if (dp_o_gnt) n++;
            step();
        end
        chk("starve_ngrants", n, 10);
        chk("starve_order", ord, 10'b1000010000);
        if_i_req = 0; dp_i_is_load = 0;
        repeat (4) step();
        bus_i_gnt = 0; bus_i_rvalid = 0;

        // Timeout, then a late response that must be dropped
        step(); dp_i_is_load = 1; dp_i_addr = 32'h300;
        @(negedge clk); chk("tmo_gnt", dp_o_gnt, 1);
        step(); dp_i_is_load = 0; bus_i_gnt = 1;
        step(); bus_i_gnt = 0;
        tw = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (dp_o_rvalid) begin tw = k; break; end
            step();
        end
        chk("tmo_cycle", tw, TMO);
        chk("tmo_err", {dp_o_err, dp_o_rdata}, {1'b1, 32'h0});
        step(); step(); bus_i_rvalid = 1; bus_i_rdata = 32'h55AA55AA;
        @(negedge clk); chk("tmo_late", {dp_o_rvalid, if_o_rvalid}, 2'b00);
        step(); bus_i_rvalid = 0;

        // Asynchronous reset while in WAIT
        step(); dp_i_is_load = 1; dp_i_addr = 32'h500;
        @(negedge clk); chk("arst_gnt0", dp_o_gnt, 1);
        step(); dp_i_is_load = 0; bus_i_gnt = 1;
        step(); bus_i_gnt = 0;
        step(); bus_i_rvalid = 1; bus_i_rdata = 32'h0BAD0BAD; dp_i_is_load = 1;
        dp_i_addr = 32'h504;
        #1 chk("arst_pre", dp_o_rvalid, 1);
        #1 rst = 0;
        #1 chk_zero("arst");
        step(); bus_i_rvalid = 0;
        step(); rst = 1;
        @(negedge clk); chk("arst_regrant", dp_o_gnt, 1);
        step(); dp_i_is_load = 0; bus_i_gnt = 1;
        step(); bus_i_gnt = 0; bus_i_rvalid = 1; bus_i_rdata = 32'h77;
        step(); bus_i_rvalid = 0;

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); g_if = if_o_gnt; g_dp = dp_o_gnt;
            step();
            if (g_if) if_i_req = 0;
            else if (!if_i_req && $urandom_range(0, 2) == 0) begin
                if_i_req = 1; if_i_addr = $urandom & ~32'h3;
            end
            if (g_dp) begin dp_i_is_load = 0; dp_i_is_store = 0; end
            else if (!(dp_i_is_load || dp_i_is_store) && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) dp_i_is_load = 1; else dp_i_is_store = 1;
                dp_i_addr = $urandom; dp_i_wmask = 4'($urandom); dp_i_wdata = $urandom;
            end
            bus_i_gnt = 1'($urandom_range(0, 1));
            bus_i_rvalid = ($urandom_range(0, 4) == 0);
            bus_i_rdata = $urandom;
        end

        if_i_req = 0; dp_i_is_load = 0; dp_i_is_store = 0; bus_i_gnt = 0; bus_i_rvalid = 0;
        repeat (20) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
